// File: rtl/nzcv_flags_unit_pkg.sv
// Shared types for the LEGv8 NZCV flag path: flag-setting op encoding,
// the packed flag nibble and its reset value.
package legv8_flags_pkg;

  typedef enum logic [1:0] {
    FOP_NONE = 2'b00,
    FOP_ADD  = 2'b01,
    FOP_SUB  = 2'b10,
    FOP_AND  = 2'b11
  } flag_op_t;

  // Field order matches the {negative,zero,carry,overflow} output nibble.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  localparam nzcv_t NZCV_RESET = 4'b0000;

endpackage

// File: rtl/nzcv_compute.sv
// Combinational NZCV generator for the EX stage: add, sub (a + ~b + 1)
// and logical and. Op none yields all-zero flags.
module nzcv_compute
  import legv8_flags_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  flag_op_t          op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output nzcv_t             nzcv
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  logic              cin;

  always_comb begin
    b_eff = b;
    cin   = 1'b0;
    if (op == FOP_SUB) begin
      b_eff = ~b;
      cin   = 1'b1;
    end
    sum = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
  end

  always_comb begin
    nzcv = NZCV_RESET;
    res  = '0;
    unique case (op)
      FOP_ADD, FOP_SUB: begin
        res    = sum[DATA_W-1:0];
        nzcv.c = sum[DATA_W];
        // Signed overflow: operand signs (b inverted for sub) agree, result sign differs.
        nzcv.v = (a[DATA_W-1] == b_eff[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
        nzcv.n = res[DATA_W-1];
        nzcv.z = (res == '0);
      end
      FOP_AND: begin
        res    = a & b;
        nzcv.n = res[DATA_W-1];
        nzcv.z = (res == '0);
      end
      default: begin
        nzcv = NZCV_RESET;
      end
    endcase
  end

endmodule

// File: rtl/nzcv_flags_unit.sv
// NZCV flag pipeline: EX compute, EX/MEM pending slot, commit to the
// architectural register as the producer leaves MEM, and branch-facing outputs.
module nzcv_flags_unit
  import legv8_flags_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter bit EX_BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        flag_op_ex,
  input  logic [DATA_W-1:0] op_a_ex,
  input  logic [DATA_W-1:0] op_b_ex,
  input  logic              stall,
  input  logic              flush_ex_mem,
  output logic              zero,
  output logic              negative,
  output logic              carry,
  output logic              overflow,
  output logic              pend_valid
);

  flag_op_t op_ex;
  nzcv_t    ex_nzcv;
  nzcv_t    pend_nzcv;
  nzcv_t    nzcv_q;
  nzcv_t    nzcv_out;

  assign op_ex = flag_op_t'(flag_op_ex);

  nzcv_compute #(.DATA_W(DATA_W)) u_compute (
    .op   (op_ex),
    .a    (op_a_ex),
    .b    (op_b_ex),
    .nzcv (ex_nzcv)
  );

  // The older setter commits from the slot on the same edge a younger one
  // loads it; flush only kills the incoming instruction, never the commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_q     <= NZCV_RESET;
      pend_nzcv  <= NZCV_RESET;
      pend_valid <= 1'b0;
    end else if (!stall) begin
      if (pend_valid) nzcv_q <= pend_nzcv;
      if (flush_ex_mem) begin
        pend_valid <= 1'b0;
      end else begin
        pend_valid <= (op_ex != FOP_NONE);
        pend_nzcv  <= ex_nzcv;
      end
    end
  end

  generate
    if (EX_BYPASS) begin : g_bypass
      assign nzcv_out = pend_valid ? pend_nzcv : nzcv_q;
    end else begin : g_arch
      assign nzcv_out = nzcv_q;
    end
  endgenerate

  assign negative = nzcv_out.n;
  assign zero     = nzcv_out.z;
  assign carry    = nzcv_out.c;
  assign overflow = nzcv_out.v;

endmodule

// File: tb/tb_nzcv_flags_unit.sv
// Directed bench for nzcv_flags_unit: an architectural-only instance and a
// bypass instance share stimulus; expected nibbles are {N,Z,C,V}.
module tb_nzcv_flags_unit;
  localparam int W = 64;
  localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset, stall, flush_ex_mem;
  logic [1:0]   flag_op_ex;
  logic [W-1:0] op_a_ex, op_b_ex;
  logic z0, n0, c0, v0, pv0;
  logic z1, n1, c1, v1, pv1;
  logic [3:0] f0, f1;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign f0 = {n0, z0, c0, v0};
  assign f1 = {n1, z1, c1, v1};

  nzcv_flags_unit #(.DATA_W(W), .EX_BYPASS(1'b0)) dut_arch (
    .clk(clk), .reset(reset), .flag_op_ex(flag_op_ex), .op_a_ex(op_a_ex),
    .op_b_ex(op_b_ex), .stall(stall), .flush_ex_mem(flush_ex_mem),
    .zero(z0), .negative(n0), .carry(c0), .overflow(v0), .pend_valid(pv0));

  nzcv_flags_unit #(.DATA_W(W), .EX_BYPASS(1'b1)) dut_byp (
    .clk(clk), .reset(reset), .flag_op_ex(flag_op_ex), .op_a_ex(op_a_ex),
    .op_b_ex(op_b_ex), .stall(stall), .flush_ex_mem(flush_ex_mem),
    .zero(z1), .negative(n1), .carry(c1), .overflow(v1), .pend_valid(pv1));

  task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    flag_op_ex = op;
    op_a_ex    = a;
    op_b_ex    = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush_ex_mem = 1'b0;
    drive(2'b00, '0, '0);
    step(); step();
    reset = 1'b0;
    vectors++;
    if (f0 !== 4'b0000 || f1 !== 4'b0000 || pv0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: arch=%b byp=%b pv=%b, expected 0000/0000/0", f0, f1, pv0);
    end
  endtask

  task automatic test_sub_equal();
    drive(2'b10, 64'd5, 64'd5);
    step();
    vectors++;
    if (f0 !== 4'b0000 || f1 !== 4'b0110 || pv0 !== 1'b1) begin
      errors++;
      $display("FAIL sub_eq_pending: arch=%b byp=%b pv=%b, expected 0000/0110/1", f0, f1, pv0);
    end
    drive(2'b00, '0, '0);
    step();
    vectors++;
    if (f0 !== 4'b0110 || f1 !== 4'b0110 || pv0 !== 1'b0) begin
      errors++;
      $display("FAIL sub_eq_commit: arch=%b byp=%b pv=%b, expected 0110/0110/0", f0, f1, pv0);
    end
  endtask

  task automatic test_add_overflow();
    drive(2'b01, MAXP, 64'd1);
    step();
    vectors++;
    if (f0 !== 4'b0110 || f1 !== 4'b1001) begin
      errors++;
      $display("FAIL add_ovf_pending: arch=%b byp=%b, expected 0110/1001", f0, f1);
    end
    drive(2'b01, ONES, 64'd1);
    step();
    vectors++;
    if (f0 !== 4'b1001 || f1 !== 4'b0110) begin
      errors++;
      $display("FAIL add_ovf_commit: arch=%b byp=%b, expected 1001/0110", f0, f1);
    end
    drive(2'b00, '0, '0);
    step();
    vectors++;
    if (f0 !== 4'b0110 || f1 !== 4'b0110) begin
      errors++;
      $display("FAIL add_wrap_commit: arch=%b byp=%b, expected 0110/0110", f0, f1);
    end
  endtask

  task automatic test_sub_borrow_persist();
    drive(2'b10, 64'd3, 64'd5);
    step();
    vectors++;
    if (f0 !== 4'b0110 || f1 !== 4'b1000) begin
      errors++;
      $display("FAIL sub_borrow_pending: arch=%b byp=%b, expected 0110/1000", f0, f1);
    end
    drive(2'b00, ONES, ONES);
    for (int i = 0; i < 11; i++) begin
      step();
      vectors++;
      if (f0 !== 4'b1000 || f1 !== 4'b1000 || pv0 !== 1'b0) begin
        errors++;
        $display("FAIL persist_%0d: arch=%b byp=%b pv=%b, expected 1000/1000/0", i, f0, f1, pv0);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(2'b10, 64'd1, 64'd1);
    step();
    drive(2'b11, 64'hF0, 64'h0F);
    step();
    vectors++;
    if (f0 !== 4'b0110 || f1 !== 4'b0100 || pv0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: arch=%b byp=%b pv=%b, expected 0110/0100/1", f0, f1, pv0);
    end
    drive(2'b00, '0, '0);
    step();
    vectors++;
    if (f0 !== 4'b0100 || f1 !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_second: arch=%b byp=%b, expected 0100/0100", f0, f1);
    end
  endtask

  task automatic test_stall();
    drive(2'b01, MAXP, 64'd1);
    step();
    stall = 1'b1;
    drive(2'b10, 64'd3, 64'd5);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) flush_ex_mem = 1'b1;
      step();
      vectors++;
      if (f0 !== 4'b0100 || f1 !== 4'b1001 || pv0 !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: arch=%b byp=%b pv=%b, expected 0100/1001/1", i, f0, f1, pv0);
      end
    end
    stall = 1'b0; flush_ex_mem = 1'b0;
    drive(2'b00, '0, '0);
    step();
    vectors++;
    if (f0 !== 4'b1001 || f1 !== 4'b1001 || pv0 !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: arch=%b byp=%b pv=%b, expected 1001/1001/0", f0, f1, pv0);
    end
  endtask

  task automatic test_flush();
    drive(2'b10, 64'd5, 64'd5);
    step();
    drive(2'b01, MAXP, 64'd1);
    flush_ex_mem = 1'b1;
    step();
    flush_ex_mem = 1'b0;
    vectors++;
    if (f0 !== 4'b0110 || f1 !== 4'b0110 || pv0 !== 1'b0) begin
      errors++;
      $display("FAIL flush_commit: arch=%b byp=%b pv=%b, expected 0110/0110/0", f0, f1, pv0);
    end
    drive(2'b00, '0, '0);
    step();
    vectors++;
    if (f0 !== 4'b0110 || f1 !== 4'b0110) begin
      errors++;
      $display("FAIL flush_killed: arch=%b byp=%b, expected 0110/0110", f0, f1);
    end
  endtask

  task automatic test_reset_pending();
    drive(2'b11, 64'hF0, 64'h0F);
    step();
    vectors++;
    if (pv0 !== 1'b1 || pv1 !== 1'b1 || f1 !== 4'b0100) begin
      errors++;
      $display("FAIL rst_pend_setup: pv=%b/%b byp=%b, expected 1/1/0100", pv0, pv1, f1);
    end
    reset = 1'b1; stall = 1'b1; flush_ex_mem = 1'b1;
    drive(2'b00, '0, '0);
    step();
    reset = 1'b0; stall = 1'b0; flush_ex_mem = 1'b0;
    vectors++;
    if (f0 !== 4'b0000 || f1 !== 4'b0000 || pv0 !== 1'b0 || pv1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_pend_clear: arch=%b byp=%b pv=%b/%b, expected 0000/0000/0/0", f0, f1, pv0, pv1);
    end
    step();
    vectors++;
    if (f0 !== 4'b0000 || f1 !== 4'b0000) begin
      errors++;
      $display("FAIL rst_pend_after: arch=%b byp=%b, expected 0000/0000", f0, f1);
    end
  endtask

  initial begin
    test_reset();
    test_sub_equal();
    test_add_overflow();
    test_sub_borrow_persist();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/nzcv_flags_unit.md
Name: nzcv_flags_unit

Overview:
- Produces, pipelines and commits the architectural NZCV condition flags for the LEGv8 pipeline.
- Computes N/Z/C/V in EX for flag-setting instructions (ADDS/ADDIS, SUBS/SUBIS/CMP, ANDS/ANDIS) and carries them through the EX/MEM slot.
- Commits the flags to the architectural register when the producing instruction leaves MEM.
- Drives zero/negative/carry/overflow straight into the conditional-branch checker in MEM.

Parameters:
- DATA_W, 64, operand width in bits; flags taken at bit DATA_W-1.
- EX_BYPASS, 0, 1 = flag outputs forward the pending EX/MEM flags when valid (early branch resolution); 0 = outputs show the committed register only.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high
- flag_op_ex  input  2  EX-stage op: 00 none, 01 add, 10 sub, 11 and
- op_a_ex  input  DATA_W  ALU operand A in EX
- op_b_ex  input  DATA_W  ALU operand B in EX (immediate already muxed in)
- stall  input  1  hold EX/MEM and MEM/WB; no advance this cycle
- flush_ex_mem  input  1  kill the instruction entering EX/MEM (branch taken)
- zero  output  1  Z flag to branch checker
- negative  output  1  N flag
- carry  output  1  C flag
- overflow  output  1  V flag
- pend_valid  output  1  EX/MEM slot holds uncommitted flags (for hazard unit)

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset, sampled on a clk edge: nzcv_q=0000, pend_valid=0, pend_nzcv=0000. All flag outputs read 0 the cycle after reset. Reset overrides stall and flush. Reset mid-operation discards pending flags.
- EX compute (combinational):
  - add: {C,res} = a + b, with a DATA_W+1-bit sum.
  - sub: {C,res} = a + ~b + 1. C=1 means no borrow (a >= b unsigned).
  - add V = (a[msb]==b[msb]) && (res[msb]!=a[msb]).
  - sub V = (a[msb]!=b[msb]) && (res[msb]!=a[msb]).
  - and: res = a & b; C=0, V=0.
  - All ops: N = res[msb]; Z = (res==0).
  - none: no flags produced.
- EX/MEM slot update per edge, in priority order:
  - reset
  - stall: hold pend_valid and pend_nzcv
  - flush_ex_mem: pend_valid <= 0
  - otherwise: pend_valid <= (flag_op_ex!=00); pend_nzcv <= computed flags
- Commit:
  - On an edge with !stall && !reset && pend_valid: nzcv_q <= pend_nzcv.
  - Commit happens as the instruction leaves MEM. Latency is 2 edges from the EX cycle to architectural visibility.
  - flush_ex_mem never cancels the commit of the instruction already in MEM; it kills only the younger one.
  - Back-to-back setters: the older commits from the slot while the younger loads the slot on the same edge. No flags are lost.
- Outputs:
  - EX_BYPASS=0: {negative,zero,carry,overflow} = nzcv_q.
  - EX_BYPASS=1: the outputs show pend_nzcv when pend_valid, else nzcv_q.
- Non-setting instructions (op none) never modify nzcv_q. Flags persist indefinitely.
- Stall lasting N cycles: outputs stay constant, and the commit occurs on the first non-stalled edge.
- Width rule: carry is taken from bit DATA_W of the extended sum. Operands are treated as unsigned for C and signed for V.

Decomposition:
- Package legv8_flags_pkg:
  - flag_op_t enum {FOP_NONE, FOP_ADD, FOP_SUB, FOP_AND} (2-bit)
  - nzcv_t packed struct {n,z,c,v}
  - constant NZCV_RESET = 4'b0000
- Sub-module nzcv_compute: purely combinational. Inputs flag_op_t, a, b; output nzcv_t. It is reused by the bench's reference model.
- The top level holds the slot registers, commit logic and output mux (about 150-200 lines total).

Test Plan:
1. Reset, then sub with a=5, b=5 -> two edges later Z=1, C=1, N=0, V=0; outputs are 0000 before the commit.
2. add with a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> N=1, V=1, C=0, Z=0. Then add with a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> Z=1, C=1, V=0.
3. sub with a=3, b=5, followed by an op-none instruction -> N=1, C=0 committed and held unchanged through the op-none instruction and 10 further idle cycles.
4. Back-to-back: sub(1,1) then and(0xF0,0x0F) -> Z=1, C=1 committed on edge k, then Z=1, C=0 on edge k+1. No flag set is dropped.
5. stall held 3 cycles with pend_valid=1 -> outputs unchanged for 3 cycles, commit on the first non-stalled edge. With stall=1 and flush_ex_mem=1 together -> the slot is held, not killed.
6. flush_ex_mem on an adds entering EX/MEM while an older subs sits in MEM -> the older flags commit and the adds flags never appear. Reset asserted with pend_valid=1 -> next cycle outputs 0000 and pend_valid=0. With EX_BYPASS=1 -> pending flags appear one cycle earlier than with EX_BYPASS=0.
